// File: rtl/cv32e41p_rf_writeback_arb_if.sv
// Writeback bus between the EX/LSU/APU result producers and the register file write arbiter.
// The master side produces results; the slave side (the arbiter) drives the register file write ports.
interface cv32e41p_rf_writeback_arb_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  en_reg_zero_i;
    logic                  ex_valid_i;
    logic [ADDR_WIDTH-1:0] ex_waddr_i;
    logic [DATA_WIDTH-1:0] ex_wdata_i;
    logic                  lsu_valid_i;
    logic [ADDR_WIDTH-1:0] lsu_waddr_i;
    logic [DATA_WIDTH-1:0] lsu_wdata_i;
    logic                  apu_valid_i;
    logic                  apu_ready_o;
    logic [ADDR_WIDTH-1:0] apu_waddr_i;
    logic [DATA_WIDTH-1:0] apu_wdata_i;
    logic [ADDR_WIDTH-1:0] raddr_check_i;
    logic                  apu_hazard_o;
    logic                  apu_pending_o;
    logic                  we_a_o;
    logic [ADDR_WIDTH-1:0] waddr_a_o;
    logic [DATA_WIDTH-1:0] wdata_a_o;
    logic                  we_b_o;
    logic [ADDR_WIDTH-1:0] waddr_b_o;
    logic [DATA_WIDTH-1:0] wdata_b_o;

    modport master (
        output en_reg_zero_i, ex_valid_i, ex_waddr_i, ex_wdata_i,
        output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        output apu_valid_i, apu_waddr_i, apu_wdata_i, raddr_check_i,
        input  apu_ready_o, apu_hazard_o, apu_pending_o,
        input  we_a_o, waddr_a_o, wdata_a_o, we_b_o, waddr_b_o, wdata_b_o
    );

    modport slave (
        input  en_reg_zero_i, ex_valid_i, ex_waddr_i, ex_wdata_i,
        input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        input  apu_valid_i, apu_waddr_i, apu_wdata_i, raddr_check_i,
        output apu_ready_o, apu_hazard_o, apu_pending_o,
        output we_a_o, waddr_a_o, wdata_a_o, we_b_o, waddr_b_o, wdata_b_o
    );
endinterface

// File: rtl/cv32e41p_rf_writeback_arb.sv
// Register file writeback arbiter: EX/LSU results go straight to ports A/B, APU results are
// buffered in a small FIFO and drained into whichever port is idle, oldest first.
module cv32e41p_rf_writeback_arb #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int APU_FIFO_DEPTH = 2
) (
    input logic clk,
    input logic rst_n,
    cv32e41p_rf_writeback_arb_if.slave bus
);
    localparam int CNT_W = $clog2(APU_FIFO_DEPTH + 1);
    localparam int PTR_W = (APU_FIFO_DEPTH > 1) ? $clog2(APU_FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(APU_FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(APU_FIFO_DEPTH - 1);

    logic [ADDR_WIDTH-1:0]     fifo_waddr [APU_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]     fifo_wdata [APU_FIFO_DEPTH];
    logic [APU_FIFO_DEPTH-1:0] fifo_valid;
    logic [PTR_W-1:0]          head_q;
    logic [PTR_W-1:0]          tail_q;
    logic [CNT_W-1:0]          count_q;

    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  head_on_b;
    logic                  head_on_a;
    logic                  head_stale;
    logic [ADDR_WIDTH-1:0] head_waddr;
    logic [DATA_WIDTH-1:0] head_wdata;
    logic                  hazard;

    logic                  we_a_d;
    logic [ADDR_WIDTH-1:0] waddr_a_d;
    logic [DATA_WIDTH-1:0] wdata_a_d;
    logic                  we_b_d;
    logic [ADDR_WIDTH-1:0] waddr_b_d;
    logic [DATA_WIDTH-1:0] wdata_b_d;

    assign empty      = (count_q == '0);
    assign full       = (count_q == FULL_CNT);
    assign push       = bus.apu_valid_i && !full;
    assign head_waddr = fifo_waddr[head_q];
    assign head_wdata = fifo_wdata[head_q];
    assign head_on_b  = !bus.lsu_valid_i && !empty;
    assign head_on_a  = !bus.ex_valid_i && !empty && !head_on_b;
    assign pop        = head_on_b || head_on_a;

    // The queued APU result is older than any same-cycle EX/LSU write, so it is dropped on a clash.
    assign head_stale = (bus.ex_valid_i && (bus.ex_waddr_i == head_waddr)) ||
                        (bus.lsu_valid_i && (bus.lsu_waddr_i == head_waddr));

    always_comb begin
        we_a_d    = 1'b0;
        waddr_a_d = '0;
        wdata_a_d = '0;
        we_b_d    = 1'b0;
        waddr_b_d = '0;
        wdata_b_d = '0;
        if (bus.lsu_valid_i) begin
            we_b_d    = 1'b1;
            waddr_b_d = bus.lsu_waddr_i;
            wdata_b_d = bus.lsu_wdata_i;
        end else if (head_on_b) begin
            we_b_d    = !head_stale;
            waddr_b_d = head_waddr;
            wdata_b_d = head_wdata;
        end
        if (bus.ex_valid_i) begin
            we_a_d    = 1'b1;
            waddr_a_d = bus.ex_waddr_i;
            wdata_a_d = bus.ex_wdata_i;
        end else if (head_on_a) begin
            we_a_d    = !head_stale;
            waddr_a_d = head_waddr;
            wdata_a_d = head_wdata;
        end
        if (!bus.en_reg_zero_i && (waddr_a_d == '0)) we_a_d = 1'b0;
        if (!bus.en_reg_zero_i && (waddr_b_d == '0)) we_b_d = 1'b0;
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < APU_FIFO_DEPTH; i++) begin
            if (fifo_valid[i] && (fifo_waddr[i] == bus.raddr_check_i)) hazard = 1'b1;
        end
        if (!bus.en_reg_zero_i && (bus.raddr_check_i == '0)) hazard = 1'b0;
    end

    assign bus.apu_ready_o   = !full;
    assign bus.apu_pending_o = !empty;
    assign bus.apu_hazard_o  = hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.we_a_o    <= 1'b0;
            bus.waddr_a_o <= '0;
            bus.wdata_a_o <= '0;
            bus.we_b_o    <= 1'b0;
            bus.waddr_b_o <= '0;
            bus.wdata_b_o <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            fifo_valid    <= '0;
            for (int i = 0; i < APU_FIFO_DEPTH; i++) begin
                fifo_waddr[i] <= '0;
                fifo_wdata[i] <= '0;
            end
        end else begin
            bus.we_a_o    <= we_a_d;
            bus.waddr_a_o <= waddr_a_d;
            bus.wdata_a_o <= wdata_a_d;
            bus.we_b_o    <= we_b_d;
            bus.waddr_b_o <= waddr_b_d;
            bus.wdata_b_o <= wdata_b_d;
            if (push) begin
                fifo_waddr[tail_q] <= bus.apu_waddr_i;
                fifo_wdata[tail_q] <= bus.apu_wdata_i;
                fifo_valid[tail_q] <= 1'b1;
                tail_q             <= (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
            end
            if (pop) begin
                fifo_valid[head_q] <= 1'b0;
                head_q             <= (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_cv32e41p_rf_writeback_arb.sv
// Scoreboard bench for the writeback arbiter: each stimulus cycle queues the expected port/flag
// state for the following cycle, which is popped and compared after the clock edge.
module tb_cv32e41p_rf_writeback_arb;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    cv32e41p_rf_writeback_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    cv32e41p_rf_writeback_arb #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .APU_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          en0;
        logic          ex_v;
        logic [AW-1:0] ex_a;
        logic [DW-1:0] ex_d;
        logic          lsu_v;
        logic [AW-1:0] lsu_a;
        logic [DW-1:0] lsu_d;
        logic          apu_v;
        logic [AW-1:0] apu_a;
        logic [DW-1:0] apu_d;
        logic [AW-1:0] raddr;
    } stim_t;

    typedef struct packed {
        logic          we_a;
        logic [AW-1:0] waddr_a;
        logic [DW-1:0] wdata_a;
        logic          we_b;
        logic [AW-1:0] waddr_b;
        logic [DW-1:0] wdata_b;
        logic          ready;
        logic          pending;
        logic          hazard;
    } exp_t;

    exp_t exp_q[$];

    function automatic stim_t mk_stim(logic en0, logic ex_v, logic [AW-1:0] ex_a, logic [DW-1:0] ex_d,
                                      logic lsu_v, logic [AW-1:0] lsu_a, logic [DW-1:0] lsu_d,
                                      logic apu_v, logic [AW-1:0] apu_a, logic [DW-1:0] apu_d,
                                      logic [AW-1:0] raddr);
        stim_t s;
        s = '{en0, ex_v, ex_a, ex_d, lsu_v, lsu_a, lsu_d, apu_v, apu_a, apu_d, raddr};
        return s;
    endfunction

    function automatic exp_t mk_exp(logic we_a, logic [AW-1:0] waddr_a, logic [DW-1:0] wdata_a,
                                    logic we_b, logic [AW-1:0] waddr_b, logic [DW-1:0] wdata_b,
                                    logic ready, logic pending, logic hazard);
        exp_t e;
        e = '{we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b, ready, pending, hazard};
        return e;
    endfunction

    // EX on addr 1 and LSU on addr 2 keep both write ports busy so APU entries stay queued.
    function automatic stim_t busy(logic [AW-1:0] apu_a, logic [DW-1:0] apu_d, logic apu_v,
                                   logic [AW-1:0] raddr, logic en0);
        return mk_stim(en0, 1'b1, 5'd1, 32'h100, 1'b1, 5'd2, 32'h200, apu_v, apu_a, apu_d, raddr);
    endfunction

    function automatic exp_t busy_exp(logic ready, logic pending, logic hazard);
        return mk_exp(1'b1, 5'd1, 32'h100, 1'b1, 5'd2, 32'h200, ready, pending, hazard);
    endfunction

    task automatic applyStimulus(input stim_t s);
        bus.en_reg_zero_i = s.en0;
        bus.ex_valid_i    = s.ex_v;
        bus.ex_waddr_i    = s.ex_a;
        bus.ex_wdata_i    = s.ex_d;
        bus.lsu_valid_i   = s.lsu_v;
        bus.lsu_waddr_i   = s.lsu_a;
        bus.lsu_wdata_i   = s.lsu_d;
        bus.apu_valid_i   = s.apu_v;
        bus.apu_waddr_i   = s.apu_a;
        bus.apu_wdata_i   = s.apu_d;
        bus.raddr_check_i = s.raddr;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        applyStimulus(mk_stim(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o, bus.we_b_o, bus.waddr_b_o, bus.wdata_b_o} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset ports: got we_a=%b %0d/%h we_b=%b %0d/%h required all 0",
                     bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o, bus.we_b_o, bus.waddr_b_o, bus.wdata_b_o);
        end
        tests_run++;
        if ({bus.apu_ready_o, bus.apu_pending_o, bus.apu_hazard_o} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL reset flags: got rdy/pend/haz=%b required 100",
                     {bus.apu_ready_o, bus.apu_pending_o, bus.apu_hazard_o});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_ex_write();
        stim_t s[$];
        exp_t  e[$];
        exp_t  g;
        s.push_back(mk_stim(1'b1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0));
        e.push_back(mk_exp(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0));
        s.push_back(mk_stim(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        e.push_back(mk_exp(0, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            applyStimulus(s[i]);
            exp_q.push_back(e[i]);
            tick();
            g = exp_q.pop_front();
            tests_run++;
            if ({bus.we_a_o, bus.we_b_o, bus.apu_ready_o, bus.apu_pending_o, bus.apu_hazard_o} !==
                {g.we_a, g.we_b, g.ready, g.pending, g.hazard}) begin
                tests_failed++;
                $display("[TB] FAIL ex_write[%0d] we_a/we_b/rdy/pend/haz: got %b required %b", i,
                         {bus.we_a_o, bus.we_b_o, bus.apu_ready_o, bus.apu_pending_o, bus.apu_hazard_o},
                         {g.we_a, g.we_b, g.ready, g.pending, g.hazard});
            end
            tests_run++;
            if ((g.we_a && ({bus.waddr_a_o, bus.wdata_a_o} !== {g.waddr_a, g.wdata_a})) ||
                (g.we_b && ({bus.waddr_b_o, bus.wdata_b_o} !== {g.waddr_b, g.wdata_b}))) begin
                tests_failed++;
                $display("[TB] FAIL ex_write[%0d] addr/data: got A %0d/%h B %0d/%h required A %0d/%h B %0d/%h", i,
                         bus.waddr_a_o, bus.wdata_a_o, bus.waddr_b_o, bus.wdata_b_o,
                         g.waddr_a, g.wdata_a, g.waddr_b, g.wdata_b);
            end
        end
    endtask

    task automatic test_apu_hold();
        stim_t s[$];
        exp_t  e[$];
        exp_t  g;
        s.push_back(busy(5'd7, 32'h11, 1, 5'd7, 1));
        e.push_back(busy_exp(1, 1, 1));
        s.push_back(busy(0, 0, 0, 5'd7, 1));
        e.push_back(busy_exp(1, 1, 1));
        s.push_back(busy(0, 0, 0, 5'd8, 1));
        e.push_back(busy_exp(1, 1, 0));
        s.push_back(mk_stim(1'b1, 1, 5'd1, 32'h101, 0, 0, 0, 0, 0, 0, 5'd7));
        e.push_back(mk_exp(1, 5'd1, 32'h101, 1, 5'd7, 32'h11, 1, 0, 0));
        s.push_back(mk_stim(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7));
        e.push_back(mk_exp(0, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            applyStimulus(s[i]);
            exp_q.push_back(e[i]);
            tick();
            g = exp_q.pop_front();
            tests_run++;
            if ({bus.we_a_o, bus.we_b_o, bus.apu_ready_o, bus.apu_pending_o, bus.apu_hazard_o} !==
                {g.we_a, g.we_b, g.ready, g.pending, g.hazard}) begin
                tests_failed++;
                $display("[TB] FAIL apu_hold[%0d] we_a/we_b/rdy/pend/haz: got %b required %b", i,
                         {bus.we_a_o, bus.we_b_o, bus.apu_ready_o, bus.apu_pending_o, bus.apu_hazard_o},
                         {g.we_a, g.we_b, g.ready, g.pending, g.hazard});
            end
            tests_run++;
            if ((g.we_a && ({bus.waddr_a_o, bus.wdata_a_o} !== {g.waddr_a, g.wdata_a})) ||
                (g.we_b && ({bus.waddr_b_o, bus.wdata_b_o} !== {g.waddr_b, g.wdata_b}))) begin
                tests_failed++;
                $display("[TB] FAIL apu_hold[%0d] addr/data: got A %0d/%h B %0d/%h required A %0d/%h B %0d/%h", i,
                         bus.waddr_a_o, bus.wdata_a_o, bus.waddr_b_o, bus.wdata_b_o,
                         g.waddr_a, g.wdata_a, g.waddr_b, g.wdata_b);
            end
        end
    endtask

    task automatic test_fifo_full();
        stim_t s[$];
        exp_t  e[$];
        exp_t  g;
        s.push_back(busy(5'd10, 32'hA0, 1, 5'd11, 1));
        e.push_back(busy_exp(1, 1, 0));
        s.push_back(busy(5'd11, 32'hA1, 1, 5'd11, 1));
        e.push_back(busy_exp(0, 1, 1));
        s.push_back(busy(5'd12, 32'hA2, 1, 5'd11, 1));
        e.push_back(busy_exp(0, 1, 1));
        s.push_back(mk_stim(1'b1, 1, 5'd1, 32'h100, 0, 0, 0, 1, 5'd12, 32'hA2, 5'd11));
        e.push_back(mk_exp(1, 5'd1, 32'h100, 1, 5'd10, 32'hA0, 1, 1, 1));
        s.push_back(mk_stim(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd12));
        e.push_back(mk_exp(0, 0, 0, 1, 5'd11, 32'hA1, 1, 0, 0));
        s.push_back(mk_stim(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd12));
        e.push_back(mk_exp(0, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            applyStimulus(s[i]);
            exp_q.push_back(e[i]);
            tick();
            g = exp_q.pop_front();
            tests_run++;
            if ({bus.we_a_o, bus.we_b_o, bus.apu_ready_o, bus.apu_pending_o, bus.apu_hazard_o} !==
                {g.we_a, g.we_b, g.ready, g.pending, g.hazard}) begin
                tests_failed++;
                $display("[TB] FAIL fifo_full[%0d] we_a/we_b/rdy/pend/haz: got %b required %b", i,
                         {bus.we_a_o, bus.we_b_o, bus.apu_ready_o, bus.apu_pending_o, bus.apu_hazard_o},
                         {g.we_a, g.we_b, g.ready, g.pending, g.hazard});
            end
            tests_run++;
            if ((g.we_a && ({bus.waddr_a_o, bus.wdata_a_o} !== {g.waddr_a, g.wdata_a})) ||
                (g.we_b && ({bus.waddr_b_o, bus.wdata_b_o} !== {g.waddr_b, g.wdata_b}))) begin
                tests_failed++;
                $display("[TB] FAIL fifo_full[%0d] addr/data: got A %0d/%h B %0d/%h required A %0d/%h B %0d/%h", i,
                         bus.waddr_a_o, bus.wdata_a_o, bus.waddr_b_o, bus.wdata_b_o,
                         g.waddr_a, g.wdata_a, g.waddr_b, g.wdata_b);
            end
        end
    endtask

    task automatic test_discard();
        stim_t s[$];
        exp_t  e[$];
        exp_t  g;
        s.push_back(busy(5'd9, 32'hAA, 1, 5'd9, 1));
        e.push_back(busy_exp(1, 1, 1));
        s.push_back(mk_stim(1'b1, 0, 0, 0, 1, 5'd9, 32'hBB, 0, 0, 0, 5'd9));
        e.push_back(mk_exp(0, 0, 0, 1, 5'd9, 32'hBB, 1, 0, 0));
        s.push_back(busy(5'd13, 32'hCC, 1, 5'd13, 1));
        e.push_back(busy_exp(1, 1, 1));
        s.push_back(mk_stim(1'b1, 0, 0, 0, 1, 5'd3, 32'h300, 0, 0, 0, 5'd13));
        e.push_back(mk_exp(1, 5'd13, 32'hCC, 1, 5'd3, 32'h300, 1, 0, 0));
        s.push_back(mk_stim(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        e.push_back(mk_exp(0, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            applyStimulus(s[i]);
            exp_q.push_back(e[i]);
            tick();
            g = exp_q.pop_front();
            tests_run++;
            if ({bus.we_a_o, bus.we_b_o, bus.apu_ready_o, bus.apu_pending_o, bus.apu_hazard_o} !==
                {g.we_a, g.we_b, g.ready, g.pending, g.hazard}) begin
                tests_failed++;
                $display("[TB] FAIL discard[%0d] we_a/we_b/rdy/pend/haz: got %b required %b", i,
                         {bus.we_a_o, bus.we_b_o, bus.apu_ready_o, bus.apu_pending_o, bus.apu_hazard_o},
                         {g.we_a, g.we_b, g.ready, g.pending, g.hazard});
            end
            tests_run++;
            if ((g.we_a && ({bus.waddr_a_o, bus.wdata_a_o} !== {g.waddr_a, g.wdata_a})) ||
                (g.we_b && ({bus.waddr_b_o, bus.wdata_b_o} !== {g.waddr_b, g.wdata_b}))) begin
                tests_failed++;
                $display("[TB] FAIL discard[%0d] addr/data: got A %0d/%h B %0d/%h required A %0d/%h B %0d/%h", i,
                         bus.waddr_a_o, bus.wdata_a_o, bus.waddr_b_o, bus.wdata_b_o,
                         g.waddr_a, g.wdata_a, g.waddr_b, g.wdata_b);
            end
        end
    endtask

    task automatic test_zero_reg();
        stim_t s[$];
        exp_t  e[$];
        exp_t  g;
        s.push_back(mk_stim(1'b0, 1, 5'd0, 32'h55, 0, 0, 0, 0, 0, 0, 0));
        e.push_back(mk_exp(0, 0, 0, 0, 0, 0, 1, 0, 0));
        s.push_back(mk_stim(1'b1, 1, 5'd0, 32'h55, 0, 0, 0, 0, 0, 0, 0));
        e.push_back(mk_exp(1, 5'd0, 32'h55, 0, 0, 0, 1, 0, 0));
        s.push_back(busy(5'd0, 32'h66, 1, 5'd0, 1));
        e.push_back(busy_exp(1, 1, 1));
        s.push_back(busy(0, 0, 0, 5'd0, 0));
        e.push_back(busy_exp(1, 1, 0));
        s.push_back(mk_stim(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        e.push_back(mk_exp(0, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            applyStimulus(s[i]);
            exp_q.push_back(e[i]);
            tick();
            g = exp_q.pop_front();
            tests_run++;
            if ({bus.we_a_o, bus.we_b_o, bus.apu_ready_o, bus.apu_pending_o, bus.apu_hazard_o} !==
                {g.we_a, g.we_b, g.ready, g.pending, g.hazard}) begin
                tests_failed++;
                $display("[TB] FAIL zero_reg[%0d] we_a/we_b/rdy/pend/haz: got %b required %b", i,
                         {bus.we_a_o, bus.we_b_o, bus.apu_ready_o, bus.apu_pending_o, bus.apu_hazard_o},
                         {g.we_a, g.we_b, g.ready, g.pending, g.hazard});
            end
            tests_run++;
            if ((g.we_a && ({bus.waddr_a_o, bus.wdata_a_o} !== {g.waddr_a, g.wdata_a})) ||
                (g.we_b && ({bus.waddr_b_o, bus.wdata_b_o} !== {g.waddr_b, g.wdata_b}))) begin
                tests_failed++;
                $display("[TB] FAIL zero_reg[%0d] addr/data: got A %0d/%h B %0d/%h required A %0d/%h B %0d/%h", i,
                         bus.waddr_a_o, bus.wdata_a_o, bus.waddr_b_o, bus.wdata_b_o,
                         g.waddr_a, g.wdata_a, g.waddr_b, g.wdata_b);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t         s;
        exp_t          g;
        logic          ex_v;
        logic          lsu_v;
        logic [AW-1:0] ex_a;
        logic [AW-1:0] lsu_a;
        logic [DW-1:0] ex_d;
        logic [DW-1:0] lsu_d;
        for (int i = 0; i < 8; i++) begin
            ex_v  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            lsu_v = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ex_a  = (i == 0) ? 5'd4 : AW'($urandom_range(1, 31));
            lsu_a = (i == 0) ? 5'd4 : AW'($urandom_range(1, 31));
            ex_d  = $urandom;
            lsu_d = $urandom;
            s = mk_stim(1'b1, ex_v, ex_a, ex_d, lsu_v, lsu_a, lsu_d, 0, 0, 0, 0);
            applyStimulus(s);
            exp_q.push_back(mk_exp(ex_v, ex_a, ex_d, lsu_v, lsu_a, lsu_d, 1, 0, 0));
            tick();
            g = exp_q.pop_front();
            tests_run++;
            if ({bus.we_a_o, bus.we_b_o, bus.apu_ready_o, bus.apu_pending_o, bus.apu_hazard_o} !==
                {g.we_a, g.we_b, g.ready, g.pending, g.hazard}) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back[%0d] we_a/we_b/rdy/pend/haz: got %b required %b", i,
                         {bus.we_a_o, bus.we_b_o, bus.apu_ready_o, bus.apu_pending_o, bus.apu_hazard_o},
                         {g.we_a, g.we_b, g.ready, g.pending, g.hazard});
            end
            tests_run++;
            if ((g.we_a && ({bus.waddr_a_o, bus.wdata_a_o} !== {g.waddr_a, g.wdata_a})) ||
                (g.we_b && ({bus.waddr_b_o, bus.wdata_b_o} !== {g.waddr_b, g.wdata_b}))) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back[%0d] addr/data: got A %0d/%h B %0d/%h required A %0d/%h B %0d/%h", i,
                         bus.waddr_a_o, bus.wdata_a_o, bus.waddr_b_o, bus.wdata_b_o,
                         g.waddr_a, g.wdata_a, g.waddr_b, g.wdata_b);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t s[$];
        exp_t  e[$];
        exp_t  g;
        s.push_back(busy(5'd3, 32'h33, 1, 5'd3, 1));
        e.push_back(busy_exp(1, 1, 1));
        s.push_back(busy(5'd4, 32'h44, 1, 5'd3, 1));
        e.push_back(busy_exp(0, 1, 1));
        s.push_back(mk_stim(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd3));
        e.push_back(mk_exp(0, 0, 0, 0, 0, 0, 1, 0, 0));
        s.push_back(mk_stim(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd4));
        e.push_back(mk_exp(0, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            applyStimulus(s[i]);
            if (i == 2) begin
                rst_n = 1'b0;
                #1;
                tests_run++;
                if ({bus.we_a_o, bus.waddr_a_o, bus.wdata_a_o, bus.we_b_o, bus.waddr_b_o, bus.wdata_b_o,
                     bus.apu_ready_o, bus.apu_pending_o, bus.apu_hazard_o} !== {{(2*(1+AW+DW)){1'b0}}, 3'b100}) begin
                    tests_failed++;
                    $display("[TB] FAIL reset_mid: got we_a=%b we_b=%b rdy/pend/haz=%b required we 0/0 flags 100",
                             bus.we_a_o, bus.we_b_o, {bus.apu_ready_o, bus.apu_pending_o, bus.apu_hazard_o});
                end
                tick();
                rst_n = 1'b1;
            end
            exp_q.push_back(e[i]);
            tick();
            g = exp_q.pop_front();
            tests_run++;
            if ({bus.we_a_o, bus.we_b_o, bus.apu_ready_o, bus.apu_pending_o, bus.apu_hazard_o} !==
                {g.we_a, g.we_b, g.ready, g.pending, g.hazard}) begin
                tests_failed++;
                $display("[TB] FAIL reset_mid[%0d] we_a/we_b/rdy/pend/haz: got %b required %b", i,
                         {bus.we_a_o, bus.we_b_o, bus.apu_ready_o, bus.apu_pending_o, bus.apu_hazard_o},
                         {g.we_a, g.we_b, g.ready, g.pending, g.hazard});
            end
            tests_run++;
            if ((g.we_a && ({bus.waddr_a_o, bus.wdata_a_o} !== {g.waddr_a, g.wdata_a})) ||
                (g.we_b && ({bus.waddr_b_o, bus.wdata_b_o} !== {g.waddr_b, g.wdata_b}))) begin
                tests_failed++;
                $display("[TB] FAIL reset_mid[%0d] addr/data: got A %0d/%h B %0d/%h required A %0d/%h B %0d/%h", i,
                         bus.waddr_a_o, bus.wdata_a_o, bus.waddr_b_o, bus.wdata_b_o,
                         g.waddr_a, g.wdata_a, g.waddr_b, g.wdata_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ex_write();
        test_apu_hold();
        test_fifo_full();
        test_discard();
        test_zero_reg();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
